// File: rtl/roic_spi_cmd_queue_if.sv
// Command / read-back bus between the ROIC register bank and the SPI command queue.
//   cmd_valid/cmd_ready : command handshake (push on valid & ready)
//   cmd_rw              : 1 = read (capture SDOUT), 0 = write
//   cmd_addr, cmd_data  : frame payload, shifted {addr,data} MSB first
//   cmd_chip_mask       : bit k selects ROIC chip k
//   rd_valid, rd_data   : one-cycle read-back strobe, chip k at [k*DATA_W +: DATA_W]
interface roic_spi_cmd_queue_if #(
    parameter int unsigned NUM_ROIC = 12,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_rw;
    logic [ADDR_W-1:0]          cmd_addr;
    logic [DATA_W-1:0]          cmd_data;
    logic [NUM_ROIC-1:0]        cmd_chip_mask;
    logic                       rd_valid;
    logic [NUM_ROIC*DATA_W-1:0] rd_data;

    // Register bank side
    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_chip_mask,
        input  cmd_ready, rd_valid, rd_data
    );

    // SPI command queue side
    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_data, cmd_chip_mask,
        output cmd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/roic_spi_cmd_queue.sv
// Queued multi-chip SPI register master for the ROIC array.
// Commands are buffered in a FIFO and issued as {addr,data} frames, MSB first,
// with per-chip active-low SEN; per-chip SDOUT is captured on reads.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   bus          : command handshake and read-back (roic_spi_cmd_queue_if.slave)
//   abort        : level; flushes the FIFO and terminates the frame in flight
//   spi_sdout    : per-chip serial data from the ROICs
//   spi_sclk     : SPI clock, idles low
//   spi_sdi      : serial data to the ROICs
//   spi_sen_n    : per-chip enable, active-low
//   busy         : frame in progress or FIFO non-empty
//   fifo_level   : occupied FIFO entries
module roic_spi_cmd_queue #(
    parameter int unsigned NUM_ROIC   = 12,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned GAP_CYC    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    roic_spi_cmd_queue_if.slave              bus,
    input  logic                             abort,
    input  logic [NUM_ROIC-1:0]              spi_sdout,
    output logic                             spi_sclk,
    output logic                             spi_sdi,
    output logic [NUM_ROIC-1:0]              spi_sen_n,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
    localparam int unsigned FRAME_W = ADDR_W + DATA_W;
    localparam int unsigned ENT_W   = 1 + FRAME_W + NUM_ROIC;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_MAX = (SCLK_DIV > GAP_CYC) ? SCLK_DIV : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t state, next_state;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [BIT_W-1:0] bit_cnt, bit_d;
    logic             phase_hi, hi_d;

    // ---------------- command FIFO ----------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push, pop, fifo_empty;
    logic [ENT_W-1:0] head;
    logic             head_rw;
    logic [FRAME_W-1:0]  head_frame;
    logic [NUM_ROIC-1:0] head_mask;

    assign bus.cmd_ready = (level != LVL_W'(FIFO_DEPTH)) && !abort;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == S_LOAD);
    assign fifo_empty    = (level == '0);
    assign head          = mem[rd_ptr];
    assign head_rw       = head[ENT_W-1];
    assign head_frame    = head[ENT_W-2 -: FRAME_W];
    assign head_mask     = head[NUM_ROIC-1:0];
    assign fifo_level    = level;

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_data, bus.cmd_chip_mask};
    end

    // FIFO pointers and level; abort flushes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // ---------------- frame sequencer ----------------
    logic sclk_end, gap_end;
    assign sclk_end = (cnt == CNT_W'(SCLK_DIV - 1));
    assign gap_end  = (cnt == CNT_W'(GAP_CYC - 1));

    // State and phase counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_d;
            bit_cnt  <= bit_d;
            phase_hi <= hi_d;
        end
    end

    // Next state; queued frames chain straight from the last GAP cycle into LOAD
    always_comb begin
        next_state = state;
        cnt_d      = cnt + CNT_W'(1);
        bit_d      = bit_cnt;
        hi_d       = phase_hi;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty && !abort) next_state = S_LOAD;
            end
            S_LOAD: begin
                cnt_d      = '0;
                next_state = (head_mask == '0) ? S_IDLE : S_SETUP;
            end
            S_SETUP: if (sclk_end) begin
                next_state = S_SHIFT;
                cnt_d      = '0;
                bit_d      = '0;
                hi_d       = 1'b0;
            end
            S_SHIFT: if (sclk_end) begin
                cnt_d = '0;
                hi_d  = !phase_hi;
                if (phase_hi) begin
                    if (bit_cnt == BIT_W'(FRAME_W - 1)) next_state = S_HOLD;
                    else                                bit_d = bit_cnt + BIT_W'(1);
                end
            end
            S_HOLD: if (sclk_end) begin
                next_state = S_GAP;
                cnt_d      = '0;
            end
            S_GAP: if (gap_end) begin
                cnt_d      = '0;
                next_state = (!fifo_empty && !abort) ? S_LOAD : S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
                cnt_d      = '0;
            end
        endcase
        if (abort && (state inside {S_LOAD, S_SETUP, S_SHIFT, S_HOLD})) begin
            next_state = S_GAP;
            cnt_d      = '0;
            hi_d       = 1'b0;
        end
    end

    // ---------------- pin / read-back datapath ----------------
    logic                       load_frame, bit_end, rd_done, sclk_d;
    logic [NUM_ROIC-1:0]        sen_n_d;
    logic [FRAME_W-1:0]         shreg;
    logic                       cur_rw;
    logic [NUM_ROIC-1:0]        cur_mask;
    logic [NUM_ROIC-1:0][DATA_W-1:0] cap;
    logic                       rd_valid_q;
    logic [NUM_ROIC*DATA_W-1:0] rd_data_q;

    assign spi_sdi      = shreg[FRAME_W-1];
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign busy         = (state != S_IDLE) || !fifo_empty;

    // Next values for the pin registers; bit_end is the edge closing a high phase
    always_comb begin
        load_frame = (state == S_LOAD) && (next_state == S_SETUP);
        bit_end    = (state == S_SHIFT) && phase_hi && sclk_end && !abort;
        rd_done    = (state == S_HOLD) && sclk_end && !abort && cur_rw;
        sclk_d     = 1'b0;
        if (state == S_SHIFT && !abort) sclk_d = sclk_end ? !phase_hi : phase_hi;
        sen_n_d    = spi_sen_n;
        if (next_state == S_GAP) sen_n_d = '1;
        else if (load_frame)     sen_n_d = ~head_mask;
    end

    // Pin registers, shift register, SDOUT capture and read-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_sclk   <= 1'b0;
            spi_sen_n  <= '1;
            shreg      <= '0;
            cur_rw     <= 1'b0;
            cur_mask   <= '0;
            cap        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            spi_sclk   <= sclk_d;
            spi_sen_n  <= sen_n_d;
            rd_valid_q <= rd_done;
            if (load_frame) begin
                shreg    <= head_frame;
                cur_rw   <= head_rw;
                cur_mask <= head_mask;
            end else if (next_state == S_GAP) begin
                shreg <= '0;
            end else if (bit_end) begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end
            // Shifting keeps only the newest DATA_W samples per chip
            if (bit_end) begin
                for (int k = 0; k < int'(NUM_ROIC); k++)
                    cap[k] <= {cap[k][DATA_W-2:0], spi_sdout[k]};
            end
            if (rd_done) begin
                for (int k = 0; k < int'(NUM_ROIC); k++)
                    rd_data_q[k*DATA_W +: DATA_W] <= cur_mask[k] ? cap[k] : '0;
            end
        end
    end
endmodule

// File: tb/tb_roic_spi_cmd_queue.sv
module tb_roic_spi_cmd_queue;
    localparam int NR = 12;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          abort;
    logic [NR-1:0] spi_sdout;
    logic          spi_sclk, spi_sdi;
    logic [NR-1:0] spi_sen_n;
    logic          busy;
    logic [3:0]    fifo_level;

    roic_spi_cmd_queue_if #(.NUM_ROIC(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    roic_spi_cmd_queue #(
        .NUM_ROIC(NR), .ADDR_W(AW), .DATA_W(DW),
        .FIFO_DEPTH(8), .SCLK_DIV(2), .GAP_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .abort(abort),
        .spi_sdout(spi_sdout), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
        .spi_sen_n(spi_sen_n), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor and chip model: chip k answers 0x1000+k in the last 16 bits
    int          bitn = 0;
    logic        in_frame = 1'b0;
    logic        prev_sclk = 1'b0;
    int          cur_rise, cur_low, cur_fall;
    logic [23:0] cur_bits;
    logic [11:0] cur_mask;
    int          q_fall[$], q_rise[$], q_low[$];
    logic [23:0] q_bits[$];
    logic [11:0] q_mask[$];
    int          rdv_cnt = 0;

    function automatic logic resp_bit(input int k, input int b);
        logic [23:0] w;
        w = 24'h001000 + 24'(k);
        return (b >= 0 && b < 24) ? w[23-b] : 1'b0;
    endfunction

    always_comb begin
        for (int k = 0; k < NR; k++) spi_sdout[k] = resp_bit(k, bitn);
    end

    always @(negedge clk) begin
        if (&spi_sen_n) bitn = 0;
        else if (prev_sclk && !spi_sclk) bitn++;
        if (!(&spi_sen_n)) begin
            if (!in_frame) begin
                in_frame = 1'b1; cur_fall = cyc; cur_mask = ~spi_sen_n;
                cur_bits = '0; cur_rise = 0; cur_low = 0;
            end
            cur_low++;
            if (spi_sclk && !prev_sclk) begin
                cur_bits = {cur_bits[22:0], spi_sdi};
                cur_rise++;
            end
        end else if (in_frame) begin
            in_frame = 1'b0;
            q_fall.push_back(cur_fall); q_rise.push_back(cur_rise);
            q_low.push_back(cur_low);   q_bits.push_back(cur_bits);
            q_mask.push_back(cur_mask);
        end
        prev_sclk = spi_sclk;
        if (bus.rd_valid === 1'b1) rdv_cnt++;
    end

    task automatic push(input logic rw, input logic [7:0] a, input logic [15:0] d,
                        input logic [11:0] m, output logic acc);
        bus.cmd_rw = rw; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_chip_mask = m;
        bus.cmd_valid = 1'b1;
        acc = bus.cmd_ready;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && q_fall.size() < n; i++) @(negedge clk);
        chk(tag, q_fall.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk(tag, busy, 1'b0);
    endtask

    task automatic clear_q();
        q_fall.delete(); q_rise.delete(); q_low.delete(); q_bits.delete(); q_mask.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [191:0] exp_rd;
    logic         acc;
    int           t0, rdv0;

    initial begin
        rst = 1'b1; abort = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0;
        bus.cmd_data = '0; bus.cmd_chip_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_sen_n", spi_sen_n, 12'hFFF);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_sdi", spi_sdi, 1'b0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_data", bus.rd_data, 192'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_ready", bus.cmd_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // 1: single write to chip 0
        rdv0 = rdv_cnt;
        push(1'b0, 8'h10, 16'hA5C3, 12'h001, acc);
        t0 = cyc;
        wait_frames(1, 400, "t1_frames");
        wait_idle("t1_idle");
        chk("t1_sen_latency", q_fall[0] - t0, 2);
        chk("t1_mask", q_mask[0], 12'h001);
        chk("t1_sen_low", q_low[0], 100);
        chk("t1_rises", q_rise[0], 24);
        chk("t1_bits", q_bits[0], 24'h10A5C3);
        chk("t1_no_rdv", rdv_cnt - rdv0, 0);
        clear_q();

        // 2: read from all chips
        rdv0 = rdv_cnt;
        push(1'b1, 8'h2F, 16'h0000, 12'hFFF, acc);
        wait_frames(1, 400, "t2_frames");
        wait_idle("t2_idle");
        for (int k = 0; k < NR; k++) exp_rd[k*16 +: 16] = 16'h1000 + 16'(k);
        chk("t2_rdv_count", rdv_cnt - rdv0, 1);
        chk("t2_rd_data", bus.rd_data, exp_rd);
        chk("t2_mask", q_mask[0], 12'hFFF);
        chk("t2_bits", q_bits[0], 24'h2F0000);
        clear_q();

        // 3: ten back-to-back offers, FIFO fills behind the first frame
        rdv0 = rdv_cnt;
        for (int i = 0; i < 10; i++) begin
            push(1'b0, 8'(8'h40 + i), 16'(16'h0101 * i), 12'(1 << i), acc);
            chk($sformatf("t3_accept%0d", i), acc, (i < 9) ? 1'b1 : 1'b0);
        end
        chk("t3_level_full", fifo_level, 4'd8);
        chk("t3_ready_full", bus.cmd_ready, 1'b0);
        wait_frames(9, 1300, "t3_frames");
        wait_idle("t3_idle");
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t3_bits%0d", i), q_bits[i], {8'(8'h40 + i), 16'(16'h0101 * i)});
            chk($sformatf("t3_mask%0d", i), q_mask[i], 12'(1 << i));
            if (i > 0) chk($sformatf("t3_spacing%0d", i), q_fall[i] - q_fall[i-1], 105);
        end
        chk("t3_no_rdv", rdv_cnt - rdv0, 0);
        chk("t3_rd_data_held", bus.rd_data, exp_rd);
        clear_q();

        // 4: empty-mask command consumed silently, then chip 11 write
        push(1'b0, 8'h55, 16'h1234, 12'h000, acc);
        t0 = cyc;
        push(1'b0, 8'h66, 16'hBEEF, 12'h800, acc);
        wait_frames(1, 400, "t4_frames");
        wait_idle("t4_idle");
        chk("t4_count", q_fall.size(), 1);
        chk("t4_latency", q_fall[0] - t0, 4);
        chk("t4_mask", q_mask[0], 12'h800);
        chk("t4_bits", q_bits[0], 24'h66BEEF);
        clear_q();

        // 4b: read with a partial mask, unselected lanes zero
        rdv0 = rdv_cnt;
        push(1'b1, 8'h30, 16'h0000, 12'h021, acc);
        wait_frames(1, 400, "t4b_frames");
        wait_idle("t4b_idle");
        exp_rd = '0;
        exp_rd[0*16 +: 16] = 16'h1000;
        exp_rd[5*16 +: 16] = 16'h1005;
        chk("t4b_rdv_count", rdv_cnt - rdv0, 1);
        chk("t4b_rd_data", bus.rd_data, exp_rd);
        clear_q();

        // 5: abort at bit 10 of a read with three writes queued
        rdv0 = rdv_cnt;
        push(1'b1, 8'h2F, 16'h0000, 12'hFFF, acc);
        push(1'b0, 8'h01, 16'h1111, 12'h002, acc);
        push(1'b0, 8'h02, 16'h2222, 12'h004, acc);
        push(1'b0, 8'h03, 16'h3333, 12'h008, acc);
        for (int i = 0; i < 400 && !(in_frame && cur_rise >= 10); i++) @(negedge clk);
        chk("t5_reached_bit10", cur_rise, 10);
        abort = 1'b1;
        bus.cmd_rw = 1'b0; bus.cmd_addr = 8'hEE; bus.cmd_data = 16'hEEEE;
        bus.cmd_chip_mask = 12'h001; bus.cmd_valid = 1'b1;
        #1;
        chk("t5_ready_abort", bus.cmd_ready, 1'b0);
        @(negedge clk);
        abort = 1'b0; bus.cmd_valid = 1'b0;
        chk("t5_sen_high", spi_sen_n, 12'hFFF);
        chk("t5_sclk_low", spi_sclk, 1'b0);
        chk("t5_level", fifo_level, 4'd0);
        chk("t5_busy_gap", busy, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_busy_last_gap", busy, 1'b1);
        @(negedge clk);
        chk("t5_busy_drop", busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_no_rdv", rdv_cnt - rdv0, 0);
        chk("t5_frames", q_fall.size(), 1);
        chk("t5_rises", q_rise[0], 10);
        chk("t5_rd_data_held", bus.rd_data, exp_rd);
        clear_q();

        // 6: asynchronous reset mid-SHIFT, then a normal write
        push(1'b0, 8'h77, 16'h0F0F, 12'h004, acc);
        for (int i = 0; i < 400 && !(in_frame && cur_rise >= 5); i++) @(negedge clk);
        chk("t6_reached_shift", cur_rise, 5);
        rst = 1'b1;
        #1;
        chk("t6_sen_n", spi_sen_n, 12'hFFF);
        chk("t6_sclk", spi_sclk, 1'b0);
        chk("t6_sdi", spi_sdi, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_level", fifo_level, 4'd0);
        chk("t6_rd_valid", bus.rd_valid, 1'b0);
        chk("t6_rd_data", bus.rd_data, 192'h0);
        chk("t6_ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_q();
        push(1'b0, 8'h99, 16'h3C3C, 12'h010, acc);
        wait_frames(1, 400, "t6_frames");
        wait_idle("t6_idle");
        chk("t6_bits", q_bits[0], 24'h993C3C);
        chk("t6_rises", q_rise[0], 24);
        chk("t6_sen_low", q_low[0], 100);
        chk("t6_mask", q_mask[0], 12'h010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
